// File: rtl/full_adder.sv
// Single-bit full adder cell; the one arithmetic element shared by serial_adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, registered carry,
// start/busy/done handshake with registered sum, carry-out and signed overflow.
module serial_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic             carry, c_msb;
    logic [CntW-1:0]  cnt;
    logic             fa_s, fa_cout;
    logic             last, accept;
    logic             unused_s_lsb;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last = (cnt == LastCnt);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (last) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            c_msb <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state_q == StRun) begin
            s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= fa_cout;
            cnt   <= cnt + CntW'(1);
            if (last) begin
                c_msb <= carry;
                sum   <= {fa_s, s_sh[WIDTH-1:1]};
                cout  <= fa_cout;
            end
        end
    end

    // c_msb and cout load together on the completing edge, so their XOR is the
    // registered overflow flag and holds with them until the next completion.
    assign overflow     = c_msb ^ cout;
    assign busy         = (state_q == StRun);
    assign done         = (state_q == StDone);
    assign unused_s_lsb = s_sh[0];

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: WIDTH 8/32/2 instances, per-cycle arithmetic reference model,
// directed handshake cases on the 8-bit instance and randomized traffic on all three.
module tb_serial_adder;

    logic             clk = 1'b0;
    logic [2:0]       rst_n, start, cin, busy, done, cout, ovf;
    logic [2:0][63:0] a, b, sum;
    int               n_checks = 0;
    int               n_pass   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int          W    = (g == 0) ? 8 : (g == 1) ? 32 : 2;
        localparam logic [63:0] Mask = (64'd1 << W) - 64'd1;

        logic [W-1:0] s;

        serial_adder #(.WIDTH(W)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .start    (start[g]),
            .a        (a[g][W-1:0]),
            .b        (b[g][W-1:0]),
            .cin      (cin[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .sum      (s),
            .cout     (cout[g]),
            .overflow (ovf[g])
        );
        assign sum[g] = 64'(s);

        // Model: k = number of rising edges so far, la = edge that accepted the
        // current op; outputs are a pure function of those and the operands.
        int          k = 0, la = 0, last_done = -1;
        bit          have = 1'b0;
        logic [63:0] p_sum = '0, v_sum = '0, am, bm;
        logic [64:0] tot;
        bit          p_cout, p_ovf, v_cout = 1'b0, v_ovf = 1'b0;
        longint      sa, sb, ss;

        initial begin
            forever begin
                @(negedge clk);
                k++;
                if (!rst_n[g]) begin
                    have = 1'b0; v_sum = '0; v_cout = 1'b0; v_ovf = 1'b0; last_done = -1;
                end else if (have && k == la + W) begin
                    v_sum = p_sum; v_cout = p_cout; v_ovf = p_ovf;
                    if (last_done >= 0)
                        chk($sformatf("w%0d_done_gap", W), 64'(k - last_done >= W + 1), 64'd1);
                    last_done = k;
                end
                chk($sformatf("w%0d_busy", W), 64'(busy[g]), 64'(have && k >= la && k < la + W));
                chk($sformatf("w%0d_done", W), 64'(done[g]), 64'(have && k == la + W));
                chk($sformatf("w%0d_sum", W), sum[g], v_sum);
                chk($sformatf("w%0d_cout", W), 64'(cout[g]), 64'(v_cout));
                chk($sformatf("w%0d_ovf", W), 64'(ovf[g]), 64'(v_ovf));
                if (rst_n[g] && start[g] && (!have || k + 1 >= la + W + 1)) begin
                    have   = 1'b1;
                    la     = k + 1;
                    am     = a[g] & Mask;
                    bm     = b[g] & Mask;
                    tot    = 65'(am) + 65'(bm) + 65'(cin[g]);
                    p_sum  = tot[63:0] & Mask;
                    p_cout = tot[W];
                    sa     = longint'(am);
                    sb     = longint'(bm);
                    if (am[W-1]) sa -= (longint'(1) << W);
                    if (bm[W-1]) sb -= (longint'(1) << W);
                    ss     = sa + sb + longint'(cin[g]);
                    p_ovf  = (ss > (longint'(1) << (W - 1)) - 1) || (ss < -(longint'(1) << (W - 1)));
                end
            end
        end
    end

    // Presents one op to the 8-bit DUT; returns 2ns after the accepting edge.
    task automatic go8(input logic [7:0] aa, input logic [7:0] bb, input logic c);
        @(posedge clk); #2;
        start[0] = 1'b1; a[0] = 64'(aa); b[0] = 64'(bb); cin[0] = c;
        @(posedge clk); #2;
        start[0] = 1'b0; a[0] = {$urandom, $urandom}; b[0] = {$urandom, $urandom};
        cin[0] = 1'($urandom_range(1, 0));
    endtask

    task automatic op8(input string nm, input logic [7:0] aa, input logic [7:0] bb,
                       input logic c, input logic [7:0] es, input logic ec, input logic eo);
        int nb = 0, nd = 0, di = -1;
        go8(aa, bb, c);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            nb += int'(busy[0]);
            if (done[0]) begin nd++; di = i; end
        end
        chk({nm, "_sum"}, sum[0], 64'(es));
        chk({nm, "_cout"}, 64'(cout[0]), 64'(ec));
        chk({nm, "_ovf"}, 64'(ovf[0]), 64'(eo));
        chk({nm, "_busy_cycles"}, 64'(nb), 64'd8);
        chk({nm, "_done_cycles"}, 64'(nd), 64'd1);
        chk({nm, "_done_edge"}, 64'(di), 64'd8);
    endtask

    task automatic directed();
        op8("t35_0a", 8'h35, 8'h0A, 1'b0, 8'h3F, 1'b0, 1'b0);
        op8("tff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("t7f_00c", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
        // start pulsed mid-RUN with other operands must be ignored
        go8(8'h10, 8'h20, 1'b0);
        @(posedge clk); @(posedge clk); #2;
        start[0] = 1'b1; a[0] = 64'h55; b[0] = 64'h66; cin[0] = 1'b1;
        @(posedge clk); #2;
        start[0] = 1'b0;
        @(negedge clk);
        chk("ign_sum_hold", sum[0], 64'h80);
        chk("ign_busy", 64'(busy[0]), 64'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("ign_done", 64'(done[0]), 64'd1);
        chk("ign_sum", sum[0], 64'h30);
        chk("ign_cout", 64'(cout[0]), 64'd0);
        // back-to-back acceptance from the DONE cycle
        go8(8'h12, 8'h34, 1'b0);
        repeat (8) @(posedge clk);
        #2;
        start[0] = 1'b1; a[0] = 64'h80; b[0] = 64'h80; cin[0] = 1'b0;
        chk("b2b_done1", 64'(done[0]), 64'd1);
        chk("b2b_busy0", 64'(busy[0]), 64'd0);
        @(posedge clk); #2;
        start[0] = 1'b0;
        chk("b2b_done_drop", 64'(done[0]), 64'd0);
        chk("b2b_busy_rise", 64'(busy[0]), 64'd1);
        chk("b2b_first_sum", sum[0], 64'h46);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("b2b_done2", 64'(done[0]), 64'd1);
        chk("b2b_sum", sum[0], 64'h00);
        chk("b2b_cout", 64'(cout[0]), 64'd1);
        chk("b2b_ovf", 64'(ovf[0]), 64'd1);
        // asynchronous reset in the middle of bit 4
        go8(8'hAA, 8'h33, 1'b0);
        repeat (4) @(posedge clk);
        #3 rst_n[0] = 1'b0;
        #1;
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_done", 64'(done[0]), 64'd0);
        chk("rst_sum", sum[0], 64'd0);
        chk("rst_cout", 64'(cout[0]), 64'd0);
        chk("rst_ovf", 64'(ovf[0]), 64'd0);
        @(posedge clk); #2;
        rst_n[0] = 1'b1;
        op8("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    endtask

    task automatic rnd(input int idx, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #2;
            start[idx] = ($urandom_range(1, 0) == 1);
            a[idx]     = {$urandom, $urandom};
            b[idx]     = {$urandom, $urandom};
            cin[idx]   = 1'($urandom_range(1, 0));
        end
        @(posedge clk); #2;
        start[idx] = 1'b0;
        repeat (40) @(posedge clk);
    endtask

    initial begin
        rst_n = '0; start = '0; cin = '0; a = '0; b = '0;
        @(negedge clk);
        chk("reset_busy", 64'(busy[0]), 64'd0);
        chk("reset_done", 64'(done[0]), 64'd0);
        chk("reset_sum", sum[0], 64'd0);
        chk("reset_cout", 64'(cout[0]), 64'd0);
        chk("reset_ovf", 64'(ovf[0]), 64'd0);
        @(posedge clk); #2;
        rst_n = '1;
        fork
            begin
                directed();
                rnd(0, 3000);
            end
            rnd(1, 70000);
            rnd(2, 8000);
        join
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1);
    end

endmodule
